// File: rtl/sort_hw_ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two Avalon-MM masters,
// with read-return routing. Define SORT_HW_RAM_ARB_STATS_EN to build grant counters.
module sort_hw_ram_arbiter #(
  parameter  int ADDR_W = 10,
  parameter  int DATA_W = 32,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic              m0_readdatavalid,
  output logic [DATA_W-1:0] m0_readdata,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic              m1_readdatavalid,
  output logic [DATA_W-1:0] m1_readdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  input  logic [DATA_W-1:0] ram_readdata,
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1
);

  logic              m0_req, m1_req;
  logic              gnt0, gnt1, gnt_any;
  logic              win_write;
  logic [ADDR_W-1:0] win_addr;
  logic [BE_W-1:0]   win_be;
  logic [DATA_W-1:0] win_wdata;

  // last_grant_q == 1 means port 1 won most recently, so port 0 wins the next tie.
  logic              last_grant_q, last_grant_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_tag_q, rd_tag_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves
  // it unassigned; a missing default would infer a latch.
  always_comb begin
    m0_req    = m0_read | m0_write;
    m1_req    = m1_read | m1_write;
    gnt0      = !reset && m0_req && (!m1_req || last_grant_q);
    gnt1      = !reset && m1_req && (!m0_req || !last_grant_q);
    gnt_any   = gnt0 | gnt1;

    win_write = gnt1 ? m1_write      : m0_write;
    win_addr  = gnt1 ? m1_address    : m0_address;
    win_be    = gnt1 ? m1_byteenable : m0_byteenable;
    win_wdata = gnt1 ? m1_writedata  : m0_writedata;

    last_grant_d = last_grant_q;
    rd_pend_d    = gnt_any && !win_write;
    rd_tag_d     = rd_tag_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    if (gnt_any) begin
      last_grant_d = gnt1;
      rd_tag_d     = gnt1;
      addr_d       = win_addr;
      be_d         = win_write ? win_be : '1;
      wdata_d      = win_wdata;
    end
  end

  // Idle cycles replay the held values so the RAM bus does not toggle.
  assign ram_chipselect = gnt_any;
  assign ram_write      = gnt_any & win_write;
  assign ram_address    = addr_d;
  assign ram_byteenable = be_d;
  assign ram_writedata  = wdata_d;

  assign m0_waitrequest = reset | (m0_req & ~gnt0);
  assign m1_waitrequest = reset | (m1_req & ~gnt1);

  // A read granted just before reset is dropped, so reset masks the return.
  assign m0_readdatavalid = rd_pend_q & ~rd_tag_q & ~reset;
  assign m1_readdatavalid = rd_pend_q &  rd_tag_q & ~reset;
  assign m0_readdata      = ram_readdata;
  assign m1_readdata      = ram_readdata;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      rd_pend_q    <= 1'b0;
      rd_tag_q     <= 1'b0;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rd_pend_q    <= rd_pend_d;
      rd_tag_q     <= rd_tag_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
    end
  end

`ifdef SORT_HW_RAM_ARB_STATS_EN
  logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (gnt0 && cnt0_q != 16'hFFFF) cnt0_d = cnt0_q + 16'd1;
    if (gnt1 && cnt1_q != 16'hFFFF) cnt1_d = cnt1_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`else
  assign grant_cnt0 = '0;
  assign grant_cnt1 = '0;
`endif

endmodule

// File: tb/tb_sort_hw_ram_arbiter.sv
// Scoreboard bench for sort_hw_ram_arbiter with a behavioural 1024x32 RAM
// (one-cycle read latency, byte-lane writes). Preload: mem[i] = 0xA0000000 | i.
module tb_sort_hw_ram_arbiter;

  typedef struct {
    logic        port;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m1_read, m0_write, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic [9:0]  ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect, ram_write;
  logic [31:0] ram_writedata, ram_readdata;
  logic [15:0] grant_cnt0, grant_cnt1;

  logic [31:0] mem [1024];
  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  sort_hw_ram_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdatavalid(m0_readdatavalid), .m0_readdata(m0_readdata),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdatavalid(m1_readdatavalid), .m1_readdata(m1_readdata),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_readdata(ram_readdata),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | i;
  end

  always @(posedge clk) begin
    if (ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) mem[ram_address][8*b +: 8] = ram_writedata[8*b +: 8];
      end else begin
        ram_readdata <= mem[ram_address];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every readdatavalid pulse must match the oldest expected read.
  always @(negedge clk) begin
    if (m0_readdatavalid || m1_readdatavalid) begin
      exp_t e;
      check("rdv_one_port", {31'd0, m0_readdatavalid & m1_readdatavalid}, 32'd0);
      if (exp_q.size() == 0) begin
        check("rdv_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rdv_port", {31'd0, m1_readdatavalid}, {31'd0, e.port});
        check("rdv_data", m1_readdatavalid ? m1_readdata : m0_readdata, e.data);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
  endtask

  task automatic drive0(input logic rd, input logic wr, input logic [9:0] a,
                        input logic [3:0] be, input logic [31:0] d);
    m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
  endtask

  task automatic drive1(input logic rd, input logic wr, input logic [9:0] a,
                        input logic [3:0] be, input logic [31:0] d);
    m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
  endtask

  task automatic do_reset();
    idle_all();
    reset = 1;
    cyc();
    reset = 0;
  endtask

  task automatic push(input logic port, input logic [31:0] data);
    exp_t e;
    e.port = port;
    e.data = data;
    exp_q.push_back(e);
  endtask

  initial begin
    int k0, k1;
    logic w;
    reset = 1;
    drive0(0, 0, 0, 0, 0);
    drive1(0, 0, 0, 0, 0);
    cyc();
    cyc();

    // Reset ignores requests.
    m0_read = 1; m1_read = 1;
    #1;
    check("rst_wait0", {31'd0, m0_waitrequest}, 32'd1);
    check("rst_wait1", {31'd0, m1_waitrequest}, 32'd1);
    check("rst_cs", {31'd0, ram_chipselect}, 32'd0);
    check("rst_rdv0", {31'd0, m0_readdatavalid}, 32'd0);
    idle_all();
    cyc();
    reset = 0;

    // Single read from m0.
    drive0(1, 0, 10'h005, 4'h0, 0);
    #1;
    check("t1_wait0", {31'd0, m0_waitrequest}, 32'd0);
    check("t1_wait1_idle", {31'd0, m1_waitrequest}, 32'd0);
    check("t1_cs", {31'd0, ram_chipselect}, 32'd1);
    check("t1_addr", {22'd0, ram_address}, 32'h005);
    check("t1_be_read", {28'd0, ram_byteenable}, 32'hF);
    push(0, 32'hA000_0005);
    cyc();
    idle_all();
    cyc();

    // Simultaneous reads after reset: port 0 first.
    do_reset();
    drive0(1, 0, 10'h010, 4'hF, 0);
    drive1(1, 0, 10'h020, 4'hF, 0);
    #1;
    check("t2_c0_wait0", {31'd0, m0_waitrequest}, 32'd0);
    check("t2_c0_wait1", {31'd0, m1_waitrequest}, 32'd1);
    push(0, 32'hA000_0010);
    cyc();
    m0_read = 0;
    #1;
    check("t2_c1_wait1", {31'd0, m1_waitrequest}, 32'd0);
    check("t2_c1_addr", {22'd0, ram_address}, 32'h020);
    push(1, 32'hA000_0020);
    cyc();
    idle_all();
    cyc();

    // Full write contention for 8 cycles: strict alternation.
    do_reset();
    k0 = 0; k1 = 0;
    for (int i = 0; i < 8; i++) begin
      drive0(0, 1, 10'h100 + 10'(k0), 4'hF, 32'h0000_1000 + k0);
      drive1(0, 1, 10'h200 + 10'(k1), 4'hF, 32'h0000_2000 + k1);
      w = i[0];
      #1;
      check("t3_wait0", {31'd0, m0_waitrequest}, {31'd0, w});
      check("t3_wait1", {31'd0, m1_waitrequest}, {31'd0, !w});
      check("t3_wr", {31'd0, ram_write}, 32'd1);
      check("t3_addr", {22'd0, ram_address}, w ? 32'h200 + k1 : 32'h100 + k0);
      cyc();
      if (w) k1++; else k0++;
    end
    idle_all();
    cyc();
    check("t3_k0", k0, 4);
    check("t3_k1", k1, 4);
`ifdef SORT_HW_RAM_ARB_STATS_EN
    check("t3_cnt0", {16'd0, grant_cnt0}, 32'd4);
    check("t3_cnt1", {16'd0, grant_cnt1}, 32'd4);
`else
    check("t3_cnt0_tied", {16'd0, grant_cnt0}, 32'd0);
    check("t3_cnt1_tied", {16'd0, grant_cnt1}, 32'd0);
`endif
    check("t3_mem_m0", mem[10'h101], 32'h0000_1001);
    check("t3_mem_m1", mem[10'h203], 32'h0000_2003);

    // Partial byte write at top address, then read back through m0.
    drive1(0, 1, 10'h3FF, 4'hF, 32'h1234_5678);
    cyc();
    drive1(0, 1, 10'h3FF, 4'h3, 32'hDEAD_BEEF);
    #1;
    check("t4_be", {28'd0, ram_byteenable}, 32'h3);
    cyc();
    idle_all();
    #1;
    check("t4_idle_cs", {31'd0, ram_chipselect}, 32'd0);
    check("t4_idle_wr", {31'd0, ram_write}, 32'd0);
    check("t4_idle_addr", {22'd0, ram_address}, 32'h3FF);
    check("t4_idle_data", ram_writedata, 32'hDEAD_BEEF);
    cyc();
    drive0(1, 0, 10'h3FF, 4'h0, 0);
    #1;
    check("t4_rd_be", {28'd0, ram_byteenable}, 32'hF);
    push(0, 32'h1234_BEEF);
    cyc();
    idle_all();
    cyc();

    // Reset in the cycle after an m1 read grant drops the read.
    drive1(1, 0, 10'h007, 4'hF, 0);
    cyc();
    idle_all();
    reset = 1;
    #1;
    check("t5_rst_rdv1", {31'd0, m1_readdatavalid}, 32'd0);
    cyc();
    reset = 0;
    drive0(1, 0, 10'h001, 4'hF, 0);
    drive1(1, 0, 10'h002, 4'hF, 0);
    #1;
    check("t5_tie_wait0", {31'd0, m0_waitrequest}, 32'd0);
    check("t5_tie_wait1", {31'd0, m1_waitrequest}, 32'd1);
    push(0, 32'hA000_0001);
    cyc();
    m0_read = 0;
    push(1, 32'hA000_0002);
    cyc();
    idle_all();
    cyc();

`ifdef SORT_HW_RAM_ARB_STATS_EN
    // Saturation: 0xFFFF + 3 grants to port 0.
    do_reset();
    drive0(0, 1, 10'h300, 4'hF, 32'h5555_AAAA);
    for (int i = 0; i < 65538; i++) cyc();
    check("t6_cnt0_sat", {16'd0, grant_cnt0}, 32'hFFFF);
    check("t6_cnt1", {16'd0, grant_cnt1}, 32'd0);
    cyc();
    check("t6_cnt0_hold", {16'd0, grant_cnt0}, 32'hFFFF);
    idle_all();
    cyc();
`endif

    cyc();
    cyc();
    check("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
